// File: rtl/behav_demux_stream.sv
// Registered 1:2 valid/ready stream demultiplexer with a 2-entry FIFO per output channel.
// Optional per-channel delivered-word counters are enabled by defining DEMUX_COUNT_EN.
module behav_demux_stream #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      out0_count,
  output logic [15:0]      out1_count
`endif
);

  logic [WIDTH-1:0] mem0_q [2];
  logic [WIDTH-1:0] mem0_d [2];
  logic [WIDTH-1:0] mem1_q [2];
  logic [WIDTH-1:0] mem1_d [2];
  logic [1:0]       occ0_q, occ0_d, occ1_q, occ1_d;
  logic [1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]       full, valid, push, pop;

  assign full  = {occ1_q == 2'd2, occ0_q == 2'd2};
  assign valid = {occ1_q != 2'd0, occ0_q != 2'd0};

  // Ready is derived from registered occupancy only; a pop this cycle cannot free a full slot.
  assign in_ready = in_sel ? !full[1] : !full[0];
  assign push     = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
  assign pop      = valid & {out1_ready, out0_ready};

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    occ0_d = occ0_q + 2'(push[0]) - 2'(pop[0]);
    occ1_d = occ1_q + 2'(push[1]) - 2'(pop[1]);
    if (push[0]) mem0_d[wptr_q[0]] = in_data;
    if (push[1]) mem1_d[wptr_q[1]] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q <= '{default: '0};
      mem1_q <= '{default: '0};
      occ0_q <= '0;
      occ1_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ0_q <= occ0_d;
      occ1_q <= occ1_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = mem0_q[rptr_q[0]];
  assign out1_data  = mem1_q[rptr_q[1]];

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  assign cnt0_d = cnt0_q + 16'(pop[0]);
  assign cnt1_d = cnt1_q + 16'(pop[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign out0_count = cnt0_q;
  assign out1_count = cnt1_q;
`endif

endmodule

// File: tb/tb_behav_demux_stream.sv
// Directed self-checking bench for behav_demux_stream; counter checks compile in with DEMUX_COUNT_EN.
module tb_behav_demux_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       in_sel;
  logic       out0_valid;
  logic       out0_ready;
  logic [1:0] out0_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [1:0] out1_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0] out0_count;
  logic [15:0] out1_count;
`endif

  int checks;
  int errors;

  behav_demux_stream #(.WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] q[$];
  logic       iv, rdy, do_pop, do_push;
  logic [1:0] dat;

  initial begin
    checks = 0;
    errors = 0;

    // Reset held for two edges with random handshake inputs
    rst        = 1'b1;
    in_valid   = 1'($urandom_range(0, 1));
    in_sel     = 1'($urandom_range(0, 1));
    in_data    = 2'($urandom_range(0, 3));
    out0_ready = 1'($urandom_range(0, 1));
    out1_ready = 1'($urandom_range(0, 1));
    tick();
    in_valid = 1'b1;
    tick();
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", 32'(out0_data), 32'd0);
    chk("rst_d1", 32'(out1_data), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
`ifdef DEMUX_COUNT_EN
    chk("rst_c0", 32'(out0_count), 32'd0);
    chk("rst_c1", 32'(out1_count), 32'd0);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_post_v0", 32'(out0_valid), 32'd0);
    chk("rst_post_v1", 32'(out1_valid), 32'd0);

    // Alternating route with both consumers ready
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b01; #1;
    chk("alt_rdy0", 32'(in_ready), 32'd1);
    tick();
    chk("alt_v0_a", 32'(out0_valid), 32'd1);
    chk("alt_d0_a", 32'(out0_data), 32'h1);
    in_sel = 1'b1; in_data = 2'b10;
    tick();
    chk("alt_v0_b", 32'(out0_valid), 32'd0);
    chk("alt_v1_b", 32'(out1_valid), 32'd1);
    chk("alt_d1_b", 32'(out1_data), 32'h2);
    in_sel = 1'b0; in_data = 2'b11;
    tick();
    chk("alt_v0_c", 32'(out0_valid), 32'd1);
    chk("alt_d0_c", 32'(out0_data), 32'h3);
    chk("alt_v1_c", 32'(out1_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("alt_v0_d", 32'(out0_valid), 32'd0);

    // Backpressure on channel 0: exactly two words absorbed
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 2'd1; #1;
    chk("bp_rdy_1", 32'(in_ready), 32'd1);
    tick();
    chk("bp_d0_1", 32'(out0_data), 32'd1);
    in_data = 2'd2; #1;
    chk("bp_rdy_2", 32'(in_ready), 32'd1);
    tick();
    chk("bp_d0_2", 32'(out0_data), 32'd1);
    in_data = 2'd3; #1;
    chk("bp_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_v", 32'(out0_valid), 32'd1);
    chk("bp_hold_d", 32'(out0_data), 32'd1);
    in_valid = 1'b0; in_sel = 1'b1; #1;
    chk("bp_other_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sel = 1'b0; out0_ready = 1'b1; #1;
    chk("bp_no_comb", 32'(in_ready), 32'd0);
    tick();
    chk("bp_pop_d", 32'(out0_data), 32'd2);
    out0_ready = 1'b0; #1;
    chk("bp_reopen", 32'(in_ready), 32'd1);
    tick();
    chk("bp_push3_d", 32'(out0_data), 32'd2);
    in_valid = 1'b0; out0_ready = 1'b1;
    tick();
    chk("bp_ord_v", 32'(out0_valid), 32'd1);
    chk("bp_ord_d", 32'(out0_data), 32'd3);
    tick();
    chk("bp_empty", 32'(out0_valid), 32'd0);

    // Isolation: channel 0 full and stalled while channel 1 streams
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 2'd1;
    tick();
    in_data = 2'd2;
    tick();
    in_sel = 1'b1; out1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 2'(k); #1;
      chk("iso_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("iso_v1", 32'(out1_valid), 32'd1);
      chk("iso_d1", 32'(out1_data), 32'(k));
      chk("iso_d0", 32'(out0_data), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("iso_v1_end", 32'(out1_valid), 32'd0);
    out0_ready = 1'b1;
    tick();
    chk("iso_d0_2", 32'(out0_data), 32'd2);
    tick();
    chk("iso_v0_end", 32'(out0_valid), 32'd0);
    out0_ready = 1'b0;

    // Random push/pop on channel 1 against a queue model
    for (int i = 0; i < 100; i++) begin
      iv  = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      dat = 2'($urandom_range(0, 3));
      in_valid = iv; in_sel = 1'b1; in_data = dat; out1_ready = rdy; #1;
      chk("rnd_rdy", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd_v1", 32'(out1_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_d1", 32'(out1_data), 32'(q[0]));
      do_pop  = (q.size() != 0) && rdy;
      do_push = iv && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(dat);
      tick();
    end
    in_valid = 1'b0; out1_ready = 1'b1;
    tick();
    tick();
    chk("rnd_drain", 32'(out1_valid), 32'd0);
    out1_ready = 1'b0;

    // Reset mid-stream discards buffered words and clears counters
    rst = 1'b1; #2;
    rst = 1'b0;
    tick();
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data = 2'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mr_v0_empty", 32'(out0_valid), 32'd0);
`ifdef DEMUX_COUNT_EN
    chk("mr_c0_5", 32'(out0_count), 32'd5);
    chk("mr_c1_0", 32'(out1_count), 32'd0);
`endif
    out0_ready = 1'b0; in_valid = 1'b1; in_data = 2'd1;
    tick();
    in_data = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("mr_buf_v", 32'(out0_valid), 32'd1);
    chk("mr_buf_d", 32'(out0_data), 32'd1);
    rst = 1'b1; #1;
    chk("mr_async_v", 32'(out0_valid), 32'd0);
    chk("mr_async_d", 32'(out0_data), 32'd0);
    chk("mr_async_rdy", 32'(in_ready), 32'd1);
`ifdef DEMUX_COUNT_EN
    chk("mr_async_c0", 32'(out0_count), 32'd0);
`endif
    in_valid = 1'b1; in_data = 2'd3; out0_ready = 1'b1;
    tick();
    chk("mr_rst_edge_v", 32'(out0_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out0_ready = 1'b0;
    tick();
    chk("mr_after_v", 32'(out0_valid), 32'd0);
    chk("mr_after_d", 32'(out0_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
